peak_window_tracker: RTL and testbench

Per-channel peak/valley extractor feeding the vibration-alarm stage. It consumes a stream of 16-bit unsigned ADC samples and tracks the running maximum and minimum over fixed windows of WINDOW_LEN valid samples. At the end of each window it publishes the window's max/min pair and a stretched `dat_max_en` strobe. The downstream alarm logic double-registers that strobe and detects its rising edge, so the strobe is held long enough to survive that. One instance is used per vibration channel (dat0..dat3).

---
 rtl/peak_window_tracker.sv | 132 +++++++++++++
 tb/tb_peak_window_tracker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/peak_window_tracker.sv
// ---------------------------------------------------------------------------
// peak_window_tracker
//
// Tracks the running maximum and minimum of a 16-bit unsigned sample stream
// over fixed windows of WINDOW_LEN valid samples. At each window end the
// window's max/min pair is published together with a window counter and a
// strobe stretched to EN_HOLD cycles, so that a downstream double-register
// plus rising-edge detector cannot miss it.
//
// Handshake: din is qualified by din_valid only. Every cycle with din_valid
// high delivers exactly one sample. There is no ready; the block always
// accepts, one sample per cycle sustained.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   clr         in   synchronous restart, drops the partial window
//                    (wins over a same-cycle din_valid)
//   din         in   16-bit unsigned sample
//   din_valid   in   sample qualifier
//   dat_max     out  maximum of the last completed window
//   dat_min     out  minimum of the last completed window
//   dat_max_en  out  window-complete strobe, high for EN_HOLD cycles
//   win_seq     out  completed-window counter, wraps 255 -> 0
//   dbg_state   out  accumulator state (0 = EMPTY, 1 = ACC)
// ---------------------------------------------------------------------------
module peak_window_tracker #(
    parameter int unsigned WINDOW_LEN = 1024,
    parameter int unsigned EN_HOLD    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic [15:0] dat_max,
    output logic [15:0] dat_min,
    output logic        dat_max_en,
    output logic [7:0]  win_seq,
    output logic        dbg_state
);

    localparam logic [15:0] LAST_CNT  = 16'(WINDOW_LEN - 1);
    localparam logic [7:0]  HOLD_LOAD = 8'(EN_HOLD);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACC   = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_count;
    logic [15:0] r_run_max;
    logic [15:0] r_run_min;
    logic [15:0] r_dat_max;
    logic [15:0] r_dat_min;
    logic [7:0]  r_win_seq;
    logic [7:0]  r_hold;
    logic        r_en;

    logic [15:0] w_new_max;
    logic [15:0] w_new_min;
    logic        w_take;
    logic        w_last;

    // Running extremes including the sample on the bus this cycle.
    assign w_new_max = (din > r_run_max) ? din : r_run_max;
    assign w_new_min = (din < r_run_min) ? din : r_run_min;

    // clr drops a same-cycle sample, so it also masks the window end.
    assign w_take = din_valid && !clr;
    assign w_last = w_take && (r_state == ST_ACC) && (r_count == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_count   <= 16'd0;
            r_run_max <= 16'd0;
            r_run_min <= 16'd0;
            r_dat_max <= 16'd0;
            r_dat_min <= 16'd0;
            r_win_seq <= 8'd0;
            r_hold    <= 8'd0;
            r_en      <= 1'b0;
        end else begin
            // Strobe stretcher. r_en tracks the next value of r_hold being
            // nonzero so the strobe is a plain flop output.
            if (w_last) begin
                r_hold <= HOLD_LOAD;
                r_en   <= 1'b1;
            end else if (r_hold != 8'd0) begin
                r_hold <= r_hold - 8'd1;
                r_en   <= (r_hold != 8'd1);
            end else begin
                r_en   <= 1'b0;
            end

            if (clr) begin
                r_state   <= ST_EMPTY;
                r_count   <= 16'd0;
                r_run_max <= 16'd0;
                r_run_min <= 16'd0;
            end else if (din_valid) begin
                if (r_state == ST_EMPTY) begin
                    r_run_max <= din;
                    r_run_min <= din;
                    r_count   <= 16'd1;
                    r_state   <= ST_ACC;
                end else if (w_last) begin
                    // Final sample is folded into the published pair; the
                    // next valid sample opens a new window with no gap.
                    r_dat_max <= w_new_max;
                    r_dat_min <= w_new_min;
                    r_win_seq <= r_win_seq + 8'd1;
                    r_count   <= 16'd0;
                    r_state   <= ST_EMPTY;
                end else begin
                    r_run_max <= w_new_max;
                    r_run_min <= w_new_min;
                    r_count   <= r_count + 16'd1;
                end
            end
        end
    end

    assign dat_max    = r_dat_max;
    assign dat_min    = r_dat_min;
    assign dat_max_en = r_en;
    assign win_seq    = r_win_seq;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_peak_window_tracker.sv
module tb_peak_window_tracker;

  localparam int WL = 8;
  localparam int EH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [15:0] din;
  logic        din_valid;
  logic [15:0] dat_max;
  logic [15:0] dat_min;
  logic        dat_max_en;
  logic [7:0]  win_seq;
  logic        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_seq;
  logic [15:0] exp_max;
  logic [15:0] exp_min;
  logic [15:0] win[WL];

  peak_window_tracker #(
    .WINDOW_LEN (WL),
    .EN_HOLD    (EH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .dat_max    (dat_max),
    .dat_min    (dat_min),
    .dat_max_en (dat_max_en),
    .win_seq    (win_seq),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Invariant on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) chk("max_ge_min", 32'(dat_max >= dat_min), 32'd1);
  end

  task automatic chk_out(input string tag);
    chk({tag, "_max"}, 32'(dat_max), 32'(exp_max));
    chk({tag, "_min"}, 32'(dat_min), 32'(exp_min));
    chk({tag, "_seq"}, 32'(win_seq), 32'(exp_seq));
  endtask

  // ---------------- drivers ----------------
  // Present inputs, let one rising edge capture them, observe 1 ns later.
  task automatic send(input logic [15:0] d, input logic v, input logic c);
    din       = d;
    din_valid = v;
    clr       = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic idle();
    send(16'h0000, 1'b0, 1'b0);
  endtask

  // Sends win[0..7] back-to-back; outputs must hold the previous pair until
  // the last sample, then show the given pair with the strobe up.
  task automatic send_window(input string tag, input logic [15:0] emax,
                             input logic [15:0] emin, input bit chk_en_low);
    for (int i = 0; i < WL; i++) begin
      send(win[i], 1'b1, 1'b0);
      if (i < WL - 1) begin
        chk({tag, "_held"}, {dat_max, dat_min, win_seq}, {exp_max, exp_min, exp_seq});
        if (chk_en_low) chk({tag, "_en_low"}, 32'(dat_max_en), 32'd0);
      end
    end
    exp_max = emax;
    exp_min = emin;
    exp_seq = exp_seq + 8'd1;
    chk_out(tag);
    chk({tag, "_en_rise"}, 32'(dat_max_en), 32'd1);
  endtask

  // Strobe already seen high once; must stay high two more cycles then drop.
  task automatic strobe_tail(input string tag, input logic c);
    send(16'h0000, 1'b0, c);
    chk({tag, "_en2"}, 32'(dat_max_en), 32'd1);
    idle();
    chk({tag, "_en3"}, 32'(dat_max_en), 32'd1);
    idle();
    chk({tag, "_en_end"}, 32'(dat_max_en), 32'd0);
    chk_out({tag, "_after"});
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    exp_max = 16'h0;
    exp_min = 16'h0;
    exp_seq = 8'h0;
    chk_out("rst_async");
    chk("rst_async_en", 32'(dat_max_en), 32'd0);
    chk("rst_async_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; clr = 1'b0; din = 16'h0; din_valid = 1'b0;
    exp_max = 16'h0; exp_min = 16'h0; exp_seq = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset");
    chk("reset_en", 32'(dat_max_en), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // 1: rising stream 0x10..0x17
    send(16'h0010, 1'b1, 1'b0);
    chk("rise_state_acc", 32'(dbg_state), 32'd1);
    for (int i = 1; i < WL - 1; i++) begin
      send(16'(16'h0010 + i), 1'b1, 1'b0);
      chk("rise_en_low", 32'(dat_max_en), 32'd0);
    end
    send(16'h0017, 1'b1, 1'b0);
    exp_max = 16'h0017; exp_min = 16'h0010; exp_seq = 8'd1;
    chk_out("rise");
    chk("rise_en_rise", 32'(dat_max_en), 32'd1);
    chk("rise_state_empty", 32'(dbg_state), 32'd0);
    strobe_tail("rise", 1'b0);

    // 2: back-to-back windows, din_valid never drops
    win = '{16'h8000, 16'h0001, 16'h1234, 16'h7FFF, 16'h0002, 16'h8000, 16'h4000, 16'h0100};
    send_window("winA", 16'h8000, 16'h0001, 1'b1);
    win = '{16'hFFFF, 16'h0000, 16'h5555, 16'hAAAA, 16'h0001, 16'hFFFE, 16'h8000, 16'h1234};
    for (int i = 0; i < WL - 1; i++) begin
      send(win[i], 1'b1, 1'b0);
      chk("winB_held", {dat_max, dat_min, win_seq}, {exp_max, exp_min, exp_seq});
      // A's strobe covers B samples 1-2, then at least 3 low cycles.
      chk("winB_en", 32'(dat_max_en), (i < EH - 1) ? 32'd1 : 32'd0);
    end
    send(win[WL-1], 1'b1, 1'b0);
    exp_max = 16'hFFFF; exp_min = 16'h0000; exp_seq = 8'd3;
    chk_out("winB");
    chk("winB_en_rise", 32'(dat_max_en), 32'd1);
    strobe_tail("winB", 1'b0);

    // 3: gappy valid, random idle cycles between samples
    win = '{16'h0300, 16'h0050, 16'h0FFF, 16'h0200, 16'h0051, 16'h0400, 16'h0E00, 16'h0060};
    for (int i = 0; i < WL; i++) begin
      send(win[i], 1'b1, 1'b0);
      if (i == WL - 1) break;
      chk("gap_en_low", 32'(dat_max_en), 32'd0);
      repeat ($urandom_range(0, 3)) begin
        idle();
        chk("gap_idle_en_low", 32'(dat_max_en), 32'd0);
        chk("gap_idle_held", {dat_max, dat_min, win_seq}, {exp_max, exp_min, exp_seq});
      end
    end
    exp_max = 16'h0FFF; exp_min = 16'h0050; exp_seq = 8'd4;
    chk_out("gap");
    chk("gap_en_rise", 32'(dat_max_en), 32'd1);
    strobe_tail("gap", 1'b0);

    // 4: clr with the 5th sample, then 8 fresh samples
    send(16'hFFF0, 1'b1, 1'b0);
    send(16'h0001, 1'b1, 1'b0);
    send(16'hFFF1, 1'b1, 1'b0);
    send(16'h0002, 1'b1, 1'b0);
    send(16'hFFFF, 1'b1, 1'b1);
    chk_out("clr_hold");
    chk("clr_state_empty", 32'(dbg_state), 32'd0);
    chk("clr_en_low", 32'(dat_max_en), 32'd0);
    win = '{16'h1500, 16'h1000, 16'h1700, 16'h1200, 16'h1300, 16'h1400, 16'h1100, 16'h1600};
    send_window("clr_win", 16'h1700, 16'h1000, 1'b1);
    // clr during a strobe must not cut it short or disturb the outputs
    strobe_tail("clr_strobe", 1'b1);

    // 5a: reset mid-strobe (cycle 2 of 3)
    win = '{16'h0020, 16'h0021, 16'h0022, 16'h0023, 16'h0024, 16'h0025, 16'h0026, 16'h0027};
    send_window("pre_rst", 16'h0027, 16'h0020, 1'b1);
    idle();
    chk("pre_rst_en2", 32'(dat_max_en), 32'd1);
    do_reset();
    idle();
    chk("post_rst_en", 32'(dat_max_en), 32'd0);
    chk_out("post_rst");

    // 5b: reset mid-window after 4 samples
    win = '{16'h0037, 16'h0036, 16'h0035, 16'h0034, 16'h0033, 16'h0032, 16'h0031, 16'h0030};
    send_window("rst_win", 16'h0037, 16'h0030, 1'b1);
    strobe_tail("rst_win", 1'b0);
    for (int i = 0; i < 4; i++) send(16'(16'h9000 + i), 1'b1, 1'b0);
    do_reset();
    win = '{16'h0040, 16'h0041, 16'h0042, 16'h0043, 16'h0044, 16'h0045, 16'h0046, 16'h0047};
    send_window("after_abort", 16'h0047, 16'h0040, 1'b1);
    strobe_tail("after_abort", 1'b0);

    // 6: 256 random windows, win_seq wraps to 0
    do_reset();
    for (int w = 0; w < 256; w++) begin
      logic [15:0] mx, mn;
      for (int i = 0; i < WL; i++) win[i] = 16'($urandom_range(0, 65535));
      mx = win[0];
      mn = win[0];
      for (int i = 1; i < WL; i++) begin
        if (win[i] > mx) mx = win[i];
        if (win[i] < mn) mn = win[i];
      end
      send_window("rand", mx, mn, 1'b0);
    end
    chk("wrap_seq", 32'(win_seq), 32'd0);
    repeat (4) idle();
    chk("wrap_en_end", 32'(dat_max_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
